// File: rtl/onchip_memory_dp_pipe.sv
// Dual-port byte-enabled on-chip RAM with two Avalon-MM slaves and a
// configurable read pipeline (1 or 2 cycles) flagged by readdatavalid.
module onchip_memory_dp_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [BE_WIDTH-1:0]   be     [2];
  logic [DATA_WIDTH-1:0] wdata  [2];
  logic [DATA_WIDTH-1:0] rdata  [2];
  logic                  rvalid [2];
  logic [1:0]            wr_en;
  logic [1:0]            rd_en;

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;

  // A write on the same port suppresses the read, so no readdatavalid is issued for it.
  always_comb begin
    wr_en[0] = clken & ~reset_req & s1_chipselect & s1_write;
    wr_en[1] = clken & ~reset_req & s2_chipselect & s2_write;
    rd_en[0] = clken & ~reset_req & s1_chipselect & s1_read & ~s1_write;
    rd_en[1] = clken & ~reset_req & s2_chipselect & s2_read & ~s2_write;
  end

  // Port 2 lanes are scheduled first so that port 1 wins any lane both ports enable.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (wr_en[1] && be[1][b]) mem[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
      if (wr_en[0] && be[0][b]) mem[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0]   ram_q;
    logic [READ_LATENCY-1:0] vld;

    // The read register samples pre-write contents, giving old data on cross-port collisions.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ram_q <= '0;
        vld   <= '0;
      end else if (clken) begin
        vld[0] <= rd_en[p];
        for (int k = 1; k < READ_LATENCY; k++) vld[k] <= vld[k-1];
        if (rd_en[p]) ram_q <= mem[addr[p]];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] out_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_q <= '0;
        else if (clken && vld[0]) out_q <= ram_q;
      end

      assign rdata[p] = out_q;
    end else begin : g_lat1
      assign rdata[p] = ram_q;
    end

    assign rvalid[p] = vld[READ_LATENCY-1];
  end

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = rvalid[1];

endmodule
